data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder end of the CPU data-side SRAM-like interface: accepts req/addr_ok address handshakes and returns data_ok/rdata in order after a fixed latency.
- Backed by an internal word-addressed memory with byte-write strobes.
- Used as the data-memory model for pipeline bring-up and as a reference responder for the MEM-side cancel and forwarding logic.
- Up to DEPTH transactions may be outstanding; responses are never reordered.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words.
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests (>=1).
- LATENCY, 2, minimum cycles from address handshake to data_ok (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- wstrb  in  4  byte enables for writes, bit i = byte i
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored
- wdata  in  32  write data
- stall  in  1  test hook; forces addr_ok low while 1
- addr_ok  out  1  request accepted this cycle when req && addr_ok
- data_ok  out  1  response valid, single-cycle pulse per transaction
- rdata  out  32  read data, valid with data_ok

Behaviour:
- Reset (resetn=0, async):
  - count, FIFO pointers and all entry timers cleared.
  - addr_ok=0, data_ok=0, rdata=0.
  - Memory contents are not reset.
  - Reset asserted mid-transaction drops all outstanding responses; no data_ok follows after release.
- addr_ok is combinational: !stall && resetn && count<DEPTH. It does not depend on req.
- Accept (req && addr_ok), processed at the same clock edge:
  - Write: mem[idx] updated per wstrb; bytes with a zero strobe are unchanged. The pushed entry has data=0.
  - Read: the entry captures mem[idx] as it stands before any write accepted in the same cycle. Only one request can be accepted per cycle, so this case is moot; the rule is stated for clarity.
  - Entry pushed with timer=LATENCY-1.
- Read-after-write: a read accepted at least one cycle after a write to the same word returns the new data.
- Timers: every valid entry with timer>0 decrements by 1 each cycle.
- Response:
  - Registered outputs: data_ok=1 and rdata=head.data in the cycle after the head entry's timer reaches 0.
  - The head is popped on that same edge.
  - Net latency: accept at edge N gives data_ok high during cycle N+LATENCY, provided no earlier entry is blocking.
  - At most one data_ok per cycle. Back-to-back accepts yield back-to-back data_ok.
  - data_ok is never backpressured; the requester must always take it.
- rdata holds its last value when data_ok=0.
- Count update:
  - +1 on accept, -1 on pop; accept and pop in the same cycle leave count unchanged.
  - Full (count==DEPTH): addr_ok=0, even if a pop occurs that cycle. No bypass.
  - Empty: data_ok=0.
- Pointers are mod DEPTH. Wrap-around must not corrupt ordering; DEPTH need not be a power of two.
- stall: suppresses only addr_ok. Outstanding entries still time out and respond.
- FSM per entry: IDLE -> WAIT (timer>0) -> READY (timer==0, head?) -> IDLE on pop. A READY non-head entry waits for the head.

Test Plan:
1. Write/read basic:
   - Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF.
   - Then read 0x10.
   - Required: two data_ok pulses, each LATENCY cycles after its accept; second has rdata=0xDEADBEEF.
2. Byte strobes:
   - Write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb 0x5, then read 0x20.
   - Required: rdata=0x11BB33DD.
3. Full and throughput:
   - Hold req=1 (reads) continuously with LATENCY=2, DEPTH=4.
   - Required: one accept per cycle; after the first response, data_ok every cycle; count never exceeds 4.
   - With LATENCY=6: addr_ok drops after 4 accepts and reasserts only after a pop.
4. Ordering and wrap:
   - Issue 10 reads to distinct preloaded words 0..9 (word i = i*0x01010101).
   - Required: 10 data_ok pulses in issue order with matching data across pointer wrap.
5. stall:
   - Assert stall while 2 reads are outstanding.
   - Required: addr_ok=0 for the whole stall; both data_ok still arrive on time; req is held and accepted the cycle stall drops.
6. Async reset mid-operation:
   - Pull resetn low between clock edges with 3 requests outstanding.
   - Required: data_ok/addr_ok/rdata go to 0 immediately; no data_ok after release; the next read returns correct memory data.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: accepts one request per cycle into an in-order queue
// and answers each with a single-cycle data_ok LATENCY cycles after its address handshake.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_READY} ent_state_t;

  logic [31:0]   mem [2**ADDR_W];
  ent_state_t    state     [DEPTH];
  ent_state_t    state_nxt [DEPTH];
  logic [TW-1:0] timer     [DEPTH];
  logic [TW-1:0] timer_nxt [DEPTH];
  logic [31:0]   ent_data  [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] idx;
  logic          accept, pop;
  logic          unused_addr_bits;

  assign idx              = addr[ADDR_W+1:2];
  assign unused_addr_bits = &{1'b0, addr[31:ADDR_W+2], addr[1:0]};

  // No bypass: a full queue refuses even when the head pops this cycle.
  assign addr_ok = !stall && resetn && (count < CW'(DEPTH));
  assign accept  = req && addr_ok;
  assign pop     = (state[head] == E_READY);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_nxt[i] = state[i];
      timer_nxt[i] = timer[i];
      case (state[i])
        E_IDLE: begin
          if (accept && tail == PW'(i)) begin
            timer_nxt[i] = TW'(LATENCY - 1);
            state_nxt[i] = (LATENCY > 1) ? E_WAIT : E_READY;
          end
        end
        E_WAIT: begin
          timer_nxt[i] = timer[i] - TW'(1);
          if (timer[i] == TW'(1)) state_nxt[i] = E_READY;
        end
        // A ready entry that is not the head holds until it reaches the head.
        E_READY: begin
          if (pop && head == PW'(i)) state_nxt[i] = E_IDLE;
        end
        default: state_nxt[i] = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i]    <= E_IDLE;
        timer[i]    <= '0;
        ent_data[i] <= '0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= state_nxt[i];
        timer[i] <= timer_nxt[i];
      end
      if (accept) begin
        ent_data[tail] <= wr ? 32'h0 : mem[idx];
        tail           <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      data_ok <= pop;
      if (pop) rdata <= ent_data[head];
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: scoreboard of expected responses with due cycles,
// an op table for basic/strobe traffic, and hand sequences for full, stall and reset.
module tb_data_sram_responder;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        resetn, req, wr, stall, req_s;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata, slow_rdata_unused;
  logic        addr_ok, data_ok, addr_ok_s, data_ok_s;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEP), .LATENCY(LAT)) u_dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .stall(stall), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEP), .LATENCY(6)) u_slow (
    .clk(clk), .resetn(resetn), .req(req_s), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .stall(1'b0), .addr_ok(addr_ok_s), .data_ok(data_ok_s), .rdata(slow_rdata_unused)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } op_t;

  typedef struct {
    logic aok;
    logic dok;
  } slow_t;

  exp_t        sb[$];
  op_t         ops[6];
  slow_t       slow_tab[10];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        took = 1'b0;
  logic [31:0] cur_exp = '0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Model: an entry is outstanding until its due cycle; responses leave in order.
  always @(negedge clk) begin
    if (!resetn) begin
      took = 1'b0;
      check(data_ok == 1'b0, "rst_data_ok", 32'(data_ok), 0);
      check(addr_ok == 1'b0, "rst_addr_ok", 32'(addr_ok), 0);
      check(rdata == 32'h0, "rst_rdata", rdata, 0);
    end else begin
      automatic logic exp_dok = (sb.size() > 0) && (sb[0].due == cyc);
      automatic logic exp_aok;
      automatic int   due;
      check(data_ok == exp_dok, "data_ok", 32'(data_ok), 32'(exp_dok));
      if (exp_dok) begin
        exp_rdata = sb[0].data;
        void'(sb.pop_front());
      end
      check(rdata == exp_rdata, "rdata", rdata, exp_rdata);
      exp_aok = !stall && (sb.size() < DEP);
      check(addr_ok == exp_aok, "addr_ok", 32'(addr_ok), 32'(exp_aok));
      took = req && exp_aok;
      if (took) begin
        due = cyc + 1 + LAT;
        if (sb.size() > 0 && due <= sb[$].due) due = sb[$].due + 1;
        sb.push_back('{cur_exp, due});
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e, output int waited);
    wr = w; addr = a; wdata = d; wstrb = s; cur_exp = e; req = 1'b1;
    waited = 0;
    forever begin
      @(posedge clk);
      if (took) break;
      waited++;
      if (waited > 200) begin
        check(1'b0, "issue_timeout", 32'(waited), 0);
        break;
      end
    end
    #1 req = 1'b0;
  endtask

  initial begin
    int w, tot;
    resetn = 1'b0; req = 1'b0; wr = 1'b0; stall = 1'b0; req_s = 1'b0;
    wstrb = '0; addr = '0; wdata = '0;

    ops[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    ops[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    ops[2] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0};
    ops[3] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0};
    ops[4] = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD};
    ops[5] = '{1'b0, 32'h13, 32'h0,        4'h0, 32'hDEADBEEF};

    slow_tab[0] = '{1'b1, 1'b0}; slow_tab[1] = '{1'b1, 1'b0};
    slow_tab[2] = '{1'b1, 1'b0}; slow_tab[3] = '{1'b1, 1'b0};
    slow_tab[4] = '{1'b0, 1'b0}; slow_tab[5] = '{1'b0, 1'b0};
    slow_tab[6] = '{1'b0, 1'b0}; slow_tab[7] = '{1'b1, 1'b1};
    slow_tab[8] = '{1'b1, 1'b1}; slow_tab[9] = '{1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic write/read, byte strobes, ignored low address bits.
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i].wr, ops[i].addr, ops[i].wdata, ops[i].wstrb, ops[i].exp, w);
      tot += w;
    end
    check(tot == 0, "ops_b2b_accepts", 32'(tot), 0);

    // Ten words preloaded, then read back-to-back across pointer wrap.
    for (int i = 0; i < 10; i++)
      issue(1'b1, 32'(i) * 4, 32'(i) * 32'h01010101, 4'hF, 32'h0, w);
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 32'(i) * 4, 32'h0, 4'h0, 32'(i) * 32'h01010101, w);
      tot += w;
    end
    check(tot == 0, "read_b2b_accepts", 32'(tot), 0);
    repeat (4) @(posedge clk);
    #1;

    // Stall with two reads outstanding; the held request goes in as stall drops.
    issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h01010101, w);
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'h02020202, w);
    stall = 1'b1;
    fork
      issue(1'b0, 32'hC, 32'h0, 4'h0, 32'h03030303, w);
      begin
        repeat (4) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    check(w == 4, "stall_release_accept", 32'(w), 4);
    repeat (6) @(posedge clk);
    #1;

    // Slow instance: four accepts fill it, addr_ok returns only after the first pop.
    wr = 1'b0; addr = 32'h0; req_s = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check(addr_ok_s == slow_tab[t].aok, "slow_addr_ok", 32'(addr_ok_s), 32'(slow_tab[t].aok));
      check(data_ok_s == slow_tab[t].dok, "slow_data_ok", 32'(data_ok_s), 32'(slow_tab[t].dok));
      @(posedge clk);
      #1;
    end
    req_s = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Async reset between edges while responses are in flight.
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h04040404, w);
    issue(1'b0, 32'h14, 32'h0, 4'h0, 32'h05050505, w);
    issue(1'b0, 32'h18, 32'h0, 4'h0, 32'h06060606, w);
    #2 resetn = 1'b0;
    #1;
    check(data_ok == 1'b0, "async_rst_data_ok", 32'(data_ok), 0);
    check(addr_ok == 1'b0, "async_rst_addr_ok", 32'(addr_ok), 0);
    check(rdata == 32'h0, "async_rst_rdata", rdata, 0);
    sb.delete();
    exp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(1'b0, 32'h1C, 32'h0, 4'h0, 32'h07070707, w);
    issue(1'b0, 32'hFFFF_F020, 32'h0, 4'h0, 32'h08080808, w);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    check(sb.size() == 0, "drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
